// File: rtl/t5_wbck.sv
// t5_wbck: write-back stage that merges ALU results and FIFO-buffered load returns
// onto the register-file write port, with per-hart load tracking and anti-starvation stalls.
module t5_wbck #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int STARVE = 8
) (
    input  logic            sclk,
    input  logic            srst_n,
    input  logic            awre,
    input  logic [1:0]      ahart,
    input  logic [4:0]      arda,
    input  logic [XLEN-1:0] ardd,
    input  logic            lvld,
    output logic            lrdy,
    input  logic [1:0]      lhart,
    input  logic [4:0]      lrda,
    input  logic [XLEN-1:0] lrdd,
    output logic            mwre,
    output logic [1:0]      mhart,
    output logic [4:0]      rd0a,
    output logic [XLEN-1:0] rd0d,
    output logic            lstall,
    output logic [3:0]      lpend
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE + 1);

    typedef struct packed {
        logic [1:0]      hart;
        logic [4:0]      rda;
        logic [XLEN-1:0] rdd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            mwre_q, mwre_d, lstall_q, lstall_d;
    logic [1:0]      mhart_q, mhart_d;
    logic [4:0]      rd0a_q, rd0a_d;
    logic [XLEN-1:0] rd0d_q, rd0d_d;
    logic            alu_live, empty, push, pop;

    always_comb begin
        alu_live = awre && (arda != '0);
        empty    = count_q == '0;
        lrdy     = srst_n && (count_q != CW'(DEPTH));
        push     = lvld && lrdy && (lrda != '0);
        pop      = !alu_live && !empty;
        head     = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = '{hart: lhart, rda: lrda, rdd: lrdd};
        // DEPTH is a power of two, so pointers wrap by natural overflow
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        starve_d = (pop || empty) ? '0 :
                   (alu_live && starve_q != SW'(STARVE)) ? starve_q + SW'(1) : starve_q;
        lstall_d = (starve_d == SW'(STARVE)) || (count_d >= CW'(DEPTH - 1));
        mwre_d   = alu_live || pop;
        mhart_d  = alu_live ? ahart : pop ? head.hart : mhart_q;
        rd0a_d   = alu_live ? arda  : pop ? head.rda  : rd0a_q;
        rd0d_d   = alu_live ? ardd  : pop ? head.rdd  : rd0d_q;
    end

    always_comb begin
        lpend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count_q) lpend[mem_q[rd_ptr_q + PW'(i)].hart] = 1'b1;
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            mwre_q   <= 1'b0;
            mhart_q  <= '0;
            rd0a_q   <= '0;
            rd0d_q   <= '0;
            lstall_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            mwre_q   <= mwre_d;
            mhart_q  <= mhart_d;
            rd0a_q   <= rd0a_d;
            rd0d_q   <= rd0d_d;
            lstall_q <= lstall_d;
        end
    end

    always_ff @(posedge sclk) mem_q <= mem_d;

    assign mwre   = mwre_q;
    assign mhart  = mhart_q;
    assign rd0a   = rd0a_q;
    assign rd0d   = rd0d_q;
    assign lstall = lstall_q;
endmodule

// File: tb/tb_t5_wbck.sv
// tb_t5_wbck: directed vector bench for the t5_wbck write-back stage.
module tb_t5_wbck;
    logic        sclk, srst_n, awre, lvld, lrdy, mwre, lstall;
    logic [1:0]  ahart, lhart, mhart;
    logic [4:0]  arda, lrda, rd0a;
    logic [31:0] ardd, lrdd, rd0d;
    logic [3:0]  lpend;
    int          ncmp = 0;
    int          nmis = 0;

    typedef struct {
        logic awre; logic [1:0] ahart; logic [4:0] arda; logic [31:0] ardd;
        logic lvld; logic [1:0] lhart; logic [4:0] lrda; logic [31:0] lrdd;
        logic mwre; logic [1:0] mhart; logic [4:0] rd0a; logic [31:0] rd0d;
        logic lstall; logic [3:0] lpend; logic lrdy;
    } vec_t;

    vec_t tbl [15];

    t5_wbck #(.XLEN(32), .DEPTH(4), .STARVE(8)) dut (
        .sclk(sclk), .srst_n(srst_n), .awre(awre), .ahart(ahart), .arda(arda), .ardd(ardd),
        .lvld(lvld), .lrdy(lrdy), .lhart(lhart), .lrda(lrda), .lrdd(lrdd),
        .mwre(mwre), .mhart(mhart), .rd0a(rd0a), .rd0d(rd0d), .lstall(lstall), .lpend(lpend)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic vec_t mk(
        input logic aw, input logic [1:0] ah, input logic [4:0] ar, input logic [31:0] ad,
        input logic lv, input logic [1:0] lh, input logic [4:0] lr, input logic [31:0] ld,
        input logic mw, input logic [1:0] mh, input logic [4:0] ma, input logic [31:0] md,
        input logic ls, input logic [3:0] lp, input logic ly);
        vec_t r;
        r.awre = aw; r.ahart = ah; r.arda = ar; r.ardd = ad;
        r.lvld = lv; r.lhart = lh; r.lrda = lr; r.lrdd = ld;
        r.mwre = mw; r.mhart = mh; r.rd0a = ma; r.rd0d = md;
        r.lstall = ls; r.lpend = lp; r.lrdy = ly;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input vec_t t, input string nm);
        awre = t.awre; ahart = t.ahart; arda = t.arda; ardd = t.ardd;
        lvld = t.lvld; lhart = t.lhart; lrda = t.lrda; lrdd = t.lrdd;
        @(posedge sclk);
        #1;
        chk({nm, ".mwre"},   32'(mwre),   32'(t.mwre));
        chk({nm, ".mhart"},  32'(mhart),  32'(t.mhart));
        chk({nm, ".rd0a"},   32'(rd0a),   32'(t.rd0a));
        chk({nm, ".rd0d"},   rd0d,        t.rd0d);
        chk({nm, ".lstall"}, 32'(lstall), 32'(t.lstall));
        chk({nm, ".lpend"},  32'(lpend),  32'(t.lpend));
        chk({nm, ".lrdy"},   32'(lrdy),   32'(t.lrdy));
    endtask

    task automatic idle_in();
        awre = 0; ahart = 0; arda = 0; ardd = 0; lvld = 0; lhart = 0; lrda = 0; lrdd = 0;
    endtask

    initial begin
        tbl[0]  = mk(1,2,5,'hDEADBEEF, 0,0,0,0,      1,2,5,'hDEADBEEF, 0,4'b0000,1);
        tbl[1]  = mk(0,0,0,0,          0,0,0,0,      0,2,5,'hDEADBEEF, 0,4'b0000,1);
        tbl[2]  = mk(1,0,1,'h11,       1,1,7,'h77,   1,0,1,'h11,       0,4'b0010,1);
        tbl[3]  = mk(1,0,0,'h5A5A,     0,0,0,0,      1,1,7,'h77,       0,4'b0000,1);
        tbl[4]  = mk(0,0,0,0,          1,3,0,'h99,   0,1,7,'h77,       0,4'b0000,1);
        tbl[5]  = mk(1,0,2,'h100,      1,0,10,'hA0,  1,0,2,'h100,      0,4'b0001,1);
        tbl[6]  = mk(1,1,3,'h101,      1,1,11,'hA1,  1,1,3,'h101,      0,4'b0011,1);
        tbl[7]  = mk(1,2,4,'h102,      1,2,12,'hA2,  1,2,4,'h102,      1,4'b0111,1);
        tbl[8]  = mk(1,3,5,'h103,      1,3,13,'hA3,  1,3,5,'h103,      1,4'b1111,0);
        tbl[9]  = mk(1,0,6,'h104,      1,0,14,'hA4,  1,0,6,'h104,      1,4'b1111,0);
        tbl[10] = mk(0,0,0,0,          0,0,0,0,      1,0,10,'hA0,      1,4'b1110,1);
        tbl[11] = mk(0,0,0,0,          0,0,0,0,      1,1,11,'hA1,      0,4'b1100,1);
        tbl[12] = mk(0,0,0,0,          0,0,0,0,      1,2,12,'hA2,      0,4'b1000,1);
        tbl[13] = mk(0,0,0,0,          0,0,0,0,      1,3,13,'hA3,      0,4'b0000,1);
        tbl[14] = mk(0,0,0,0,          0,0,0,0,      0,3,13,'hA3,      0,4'b0000,1);

        idle_in();
        srst_n = 1'b1;
        #2 srst_n = 1'b0;
        #1;
        chk("rst.mwre",   32'(mwre),   0);
        chk("rst.lstall", 32'(lstall), 0);
        chk("rst.lpend",  32'(lpend),  0);
        chk("rst.lrdy",   32'(lrdy),   0);
        chk("rst.rd0d",   rd0d,        0);
        repeat (2) @(posedge sclk);
        #1 srst_n = 1'b1;

        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("row%0d", i));

        step(mk(1,0,1,0, 1,2,9,'h55, 1,0,1,0, 0,4'b0100,1), "stv.push");
        for (int k = 1; k <= 9; k++)
            step(mk(1,0,1,32'(k), 0,0,0,0, 1,0,1,32'(k), k >= 8, 4'b0100,1), $sformatf("stv.blk%0d", k));
        step(mk(0,0,0,0, 0,0,0,0, 1,2,9,'h55, 0,4'b0000,1), "stv.drain");

        step(mk(1,3,2,'h200, 1,0,16,'h1000, 1,3,2,'h200, 0,4'b0001,1), "pp.fill0");
        step(mk(1,3,2,'h201, 1,1,17,'h1001, 1,3,2,'h201, 0,4'b0011,1), "pp.fill1");
        for (int j = 0; j < 8; j++)
            step(mk(0,0,0,0, 1,2'((j+2)%4),5'(18+j),32'('h1002+j),
                    1,2'(j%4),5'(16+j),32'('h1000+j), 0,
                    4'((1 << ((j+1)%4)) | (1 << ((j+2)%4))),1), $sformatf("pp.x%0d", j));
        step(mk(0,0,0,0, 0,0,0,0, 1,0,24,'h1008, 0,4'b0010,1), "pp.drain8");
        step(mk(0,0,0,0, 0,0,0,0, 1,1,25,'h1009, 0,4'b0000,1), "pp.drain9");

        step(mk(1,1,3,'h300, 1,0,20,'hB0, 1,1,3,'h300, 0,4'b0001,1), "mr.q0");
        step(mk(1,1,3,'h301, 1,1,21,'hB1, 1,1,3,'h301, 0,4'b0011,1), "mr.q1");
        step(mk(1,1,3,'h302, 1,2,22,'hB2, 1,1,3,'h302, 1,4'b0111,1), "mr.q2");
        idle_in();
        srst_n = 1'b0;
        #1;
        chk("mr.mwre",   32'(mwre),   0);
        chk("mr.lstall", 32'(lstall), 0);
        chk("mr.lpend",  32'(lpend),  0);
        chk("mr.lrdy",   32'(lrdy),   0);
        @(posedge sclk);
        #1;
        chk("mr.hold_mwre", 32'(mwre), 0);
        srst_n = 1'b1;
        step(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,4'b0000,1), "mr.idle0");
        step(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,4'b0000,1), "mr.idle1");
        step(mk(0,0,0,0, 1,1,20,'hC0, 0,0,0,0, 0,4'b0010,1), "mr.push");
        step(mk(0,0,0,0, 0,0,0,0, 1,1,20,'hC0, 0,4'b0000,1), "mr.drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end
endmodule
